// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
package regfile_mp_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    // x0: reads as zero, never stored, never marked busy
    localparam reg_addr_t ZERO_REG = '0;

    // Write port that wins when both ports target the same register
    localparam int unsigned WR_PRIO_PORT = 1;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard: set on issue, clear on accepted writeback, looked up per read port.
// Optional feature: REGFILE_MP_BYPASS_EN makes a same-cycle writeback hide the busy bit.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWR-1:0]          wr_ok_i,
    input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
    input  logic                    iss_en_i,
    input  logic [AW-1:0]           iss_addr_i,
    input  logic [NRD-1:0][AW-1:0]  rd_addr_i,
    output logic [NRD-1:0]          rd_busy_o,
    output logic [NREGS-1:0]        busy_vec_o
);

    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;
    logic             iss_ok;

    assign iss_ok     = rst && iss_en_i && (iss_addr_i != AW'(ZERO_REG));
    assign busy_vec_o = {busy_q, 1'b0};

    // Next busy state: writebacks clear first, then an issue sets (new producer outstanding)
    always_comb begin
        busy_d = busy_q;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_ok_i[p]) busy_d[wr_addr_i[p]] = 1'b0;
        end
        if (iss_ok) busy_d[iss_addr_i] = 1'b1;
    end

    // Busy flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    // Per-port busy lookup
    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_busy_o[i] = 1'b0;
            if (rd_addr_i[i] != AW'(ZERO_REG)) rd_busy_o[i] = busy_q[rd_addr_i[i]];
`ifdef REGFILE_MP_BYPASS_EN
            // A matching writeback retires the producer now, unless a new one issues alongside it
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_ok_i[p] && (wr_addr_i[p] == rd_addr_i[i]))
                    rd_busy_o[i] = iss_ok && (iss_addr_i == rd_addr_i[i]);
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a RAW scoreboard.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    parameter  int unsigned NWR   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [NREGS-1:0]         busy_vec
);

    // Highest-priority port, folded to port 0 when only one write port exists
    localparam int unsigned HI = (WR_PRIO_PORT < NWR) ? WR_PRIO_PORT : 0;

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic [NWR-1:0]  wr_ok;

    // A write is accepted only out of reset and when it targets a real register
    always_comb begin
        for (int unsigned p = 0; p < NWR; p++)
            wr_ok[p] = rst && wr_en[p] && (wr_addr[p] != AW'(ZERO_REG));
    end

    // Write arbitration: low-priority ports first, the priority port last so it overrides
    always_comb begin
        regs_d = regs_q;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (p != HI && wr_ok[p]) regs_d[wr_addr[p]] = wr_data[p];
        end
        if (wr_ok[HI]) regs_d[wr_addr[HI]] = wr_data[HI];
    end

    // Register storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 1; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes, with optional same-cycle forwarding from the write ports
    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data[i] = '0;
            if (rst && rd_addr[i] != AW'(ZERO_REG)) rd_data[i] = regs_q[rd_addr[i]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int unsigned p = 0; p < NWR; p++) begin
                if (p != HI && wr_ok[p] && wr_addr[p] == rd_addr[i]) rd_data[i] = wr_data[p];
            end
            if (wr_ok[HI] && wr_addr[HI] == rd_addr[i]) rd_data[i] = wr_data[HI];
`endif
        end
    end

    regfile_mp_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_ok_i    (wr_ok),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .rd_addr_i  (rd_addr),
        .rd_busy_o  (rd_busy),
        .busy_vec_o (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 2R/2W build plus a 4R/1W build).
// Expectations follow REGFILE_MP_BYPASS_EN when the bench is compiled with it.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             iss_en;
    logic [4:0]       iss_addr;
    logic [31:0]      busy_vec;

    logic [3:0][4:0]  rd_addr4;
    logic [3:0][31:0] rd_data4;
    logic [3:0]       rd_busy4;
    logic [0:0]       wr_en4;
    logic [0:0][4:0]  wr_addr4;
    logic [0:0][31:0] wr_data4;
    logic             iss_en4;
    logic [4:0]       iss_addr4;
    logic [31:0]      busy_vec4;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(1)) dut4 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .iss_en(iss_en4), .iss_addr(iss_addr4), .busy_vec(busy_vec4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m4 [1:4];

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed %h expected <queued value>", obs);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Protocol: issuing to a busy register is only legal when that register retires in the same cycle
    always @(posedge clk) begin
        if (rst && iss_en && iss_addr != 5'd0) begin
            assert (!(busy_vec[iss_addr] &&
                      !(wr_en[0] && wr_addr[0] == iss_addr) &&
                      !(wr_en[1] && wr_addr[1] == iss_addr))) else begin
                errors++;
                $error("FAIL waw_issue observed busy x%0d expected idle", iss_addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
        rd_addr4 = '0; wr_en4 = '0; wr_addr4 = '0; wr_data4 = '0; iss_en4 = 1'b0; iss_addr4 = '0;

        // Reset held across an edge with a write and an issue presented
        repeat (2) @(negedge clk);
        wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 32'hAAAA_5555;
        iss_en = 1'b1; iss_addr = 5'd11;
        rd_addr[0] = 5'd10; rd_addr[1] = 5'd11;
        wr_en4 = 1'b1; wr_addr4[0] = 5'd10; wr_data4[0] = 32'h5555_AAAA;
        #1;
        push_exp("rst_rd_data0", 32'h0);  check(rd_data[0]);
        push_exp("rst_rd_busy1", 32'h0);  check(32'(rd_busy[1]));
        push_exp("rst_busy_vec", 32'h0);  check(busy_vec);
        @(negedge clk);
        rst = 1'b1;
        wr_en = '0; iss_en = 1'b0; wr_en4 = '0;

        // Every register on both ports reads zero after release
        for (int r = 0; r < 32; r++) begin
            rd_addr[0] = 5'(r);
            rd_addr[1] = 5'(31 - r);
            #1;
            push_exp($sformatf("post_rst_p0_x%0d", r), 32'h0);      check(rd_data[0]);
            push_exp($sformatf("post_rst_p1_x%0d", 31 - r), 32'h0); check(rd_data[1]);
        end
        push_exp("post_rst_busy_vec", 32'h0); check(busy_vec);

        // x5 via port 0, dropped write to x0 via port 1
        @(negedge clk);
        wr_en = 2'b11;
        wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
        wr_addr[1] = 5'd0; wr_data[1] = 32'h1234_5678;
        @(negedge clk);
        wr_en = '0;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
        #1;
        push_exp("x5_read", 32'hDEAD_BEEF); check(rd_data[0]);
        push_exp("x0_read", 32'h0);         check(rd_data[1]);
        push_exp("x0_busy", 32'h0);         check(32'(rd_busy[1]));
        push_exp("x0_wr_busy_vec", 32'h0);  check(busy_vec);

        // Both ports write x7: port 1 wins
        @(negedge clk);
        wr_en = 2'b11;
        wr_addr[0] = 5'd7; wr_data[0] = 32'h0000_1111;
        wr_addr[1] = 5'd7; wr_data[1] = 32'h0000_2222;
        rd_addr[0] = 5'd7;
        #1;
        push_exp("x7_same_cycle", BYP ? 32'h0000_2222 : 32'h0); check(rd_data[0]);
        @(negedge clk);
        wr_en = '0;
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
        #1;
        push_exp("x7_prio_p0", 32'h0000_2222); check(rd_data[0]);
        push_exp("x7_prio_p1", 32'h0000_2222); check(rd_data[1]);

        // Scoreboard: issue x3, writeback+reissue keeps it busy, plain writeback clears it
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr[0] = 5'd3;
        #1;
        push_exp("x3_busy_before_edge", 32'h0); check(32'(rd_busy[0]));
        @(negedge clk);
        iss_en = 1'b0;
        #1;
        push_exp("x3_busy_vec_set", 32'h0000_0008); check(busy_vec);
        push_exp("x3_rd_busy_set", 32'h1);          check(32'(rd_busy[0]));
        @(negedge clk);
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h0000_0033;
        iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        push_exp("x3_wr_iss_rd_busy", 32'h1);                     check(32'(rd_busy[0]));
        push_exp("x3_wr_iss_rd_data", BYP ? 32'h0000_0033 : 32'h0); check(rd_data[0]);
        @(negedge clk);
        wr_en = '0; iss_en = 1'b0;
        #1;
        push_exp("x3_busy_held", 32'h0000_0008); check(busy_vec);
        push_exp("x3_data_33", 32'h0000_0033);   check(rd_data[0]);
        @(negedge clk);
        wr_en = 2'b10; wr_addr[1] = 5'd3; wr_data[1] = 32'h0000_0044;
        #1;
        push_exp("x3_wb_rd_busy", BYP ? 32'h0 : 32'h1); check(32'(rd_busy[0]));
        @(negedge clk);
        wr_en = '0;
        #1;
        push_exp("x3_busy_cleared", 32'h0);    check(busy_vec);
        push_exp("x3_rd_busy_clr", 32'h0);     check(32'(rd_busy[0]));
        push_exp("x3_data_44", 32'h0000_0044); check(rd_data[0]);

        // Writeback of x9 meets its reader in the same cycle
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd9;
        @(negedge clk);
        iss_en = 1'b0;
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h0000_CAFE;
        rd_addr[1] = 5'd9;
        #1;
        push_exp("x9_same_cycle_data", BYP ? 32'h0000_CAFE : 32'h0); check(rd_data[1]);
        push_exp("x9_same_cycle_busy", BYP ? 32'h0 : 32'h1);         check(32'(rd_busy[1]));
        @(negedge clk);
        wr_en = '0;
        #1;
        push_exp("x9_next_data", 32'h0000_CAFE); check(rd_data[1]);
        push_exp("x9_next_busy_vec", 32'h0);     check(busy_vec);

        // 4-read / 1-write build
        for (int r = 1; r <= 4; r++) begin
            m4[r] = 32'h4000_0000 | (32'(r) * 32'h0001_0101);
            @(negedge clk);
            wr_en4 = 1'b1; wr_addr4[0] = 5'(r); wr_data4[0] = m4[r];
        end
        @(negedge clk);
        wr_en4 = '0;
        for (int i = 0; i < 4; i++) rd_addr4[i] = 5'(i + 1);
        #1;
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("nrd4_port%0d", i), m4[i + 1]);
            check(rd_data4[i]);
        end
        for (int i = 0; i < 4; i++) rd_addr4[i] = 5'd2;
        #1;
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("nrd4_same_port%0d", i), m4[2]);
            check(rd_data4[i]);
        end
        rd_addr4[0] = 5'd10;
        #1;
        push_exp("nrd4_x10_rst_write", 32'h0); check(rd_data4[0]);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a built-in scoreboard, replacing the single-write 2-read register file in the core. It provides `NRD` combinational read ports and `NWR` synchronous write ports, with register 0 hardwired to zero. A per-register busy bit tracks registers whose producer has issued but not yet written back, so the decode stage can stall on RAW hazards.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, register count including x0; a power of two, at least 2; AW = $clog2(NREGS)
- NRD, 2, number of read ports, 1..4
- NWR, 2, number of write ports, 1..2; port index 1 has the higher priority

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data, combinational
- rd_busy  out  NRD  busy bit of each addressed register, combinational
- wr_en  in  NWR  write enables
- wr_addr  in  NWR×AW  write addresses
- wr_data  in  NWR×XLEN  write data
- iss_en  in  1  issue strobe: marks iss_addr as pending
- iss_addr  in  AW  destination of the issuing instruction
- busy_vec  out  NREGS  all busy bits; bit 0 is always 0

## Operation
- **Storage:** registers 1..NREGS-1 are flops. x0 is not stored. Reads of x0 return 0 with rd_busy=0.
- **Writes:**
  - A write lands on the rising edge when wr_en[p]=1 and wr_addr[p]≠0.
  - If both ports write the same register in one cycle, port 1 wins.
  - Writes to x0 are dropped and do not touch the scoreboard.
- **Scoreboard set:** iss_en=1 with iss_addr≠0 sets busy[iss_addr] on the edge.
- **Scoreboard clear:** any accepted write to register r clears busy[r] on the edge.
- **Issue and writeback to the same register in one cycle:** set wins and busy stays 1, because the new producer is still outstanding.
- **Issue to a register that is already busy (WAW):** illegal. The bench asserts on it. RTL behaviour is unchanged: the bit stays 1.
- **Reads:**
  - rd_data[i] = regs[rd_addr[i]], or the bypassed write data (see Configuration).
  - rd_busy[i] = busy[rd_addr[i]], with bypass adjustment.
  - Ports are independent, and any number may read the same address.
- **Reset (rst=0):**
  - All registers clear to 0 and all busy bits clear asynchronously.
  - rd_data, rd_busy and busy_vec are forced to 0 while rst=0.
  - Writes and issues during reset are ignored.
  - Deassertion mid-stream needs no recovery sequence: the first edge after release may write.

## Timing
- Write latency is 1 cycle: data written at edge N is visible on rd_data combinationally after edge N.
- Scoreboard latency is 1 cycle for both set and clear. busy_vec is a direct flop output.
- No handshake: every write and issue is accepted unconditionally in the cycle it is presented.
- Read paths are purely combinational, so consumers register them as required.
- Worst-case path is rd_addr → mux → rd_data. With bypass enabled it also includes the wr_addr compare.

## Configuration
- Macro: `REGFILE_MP_BYPASS_EN`.
- **Defined:**
  - If a read address matches an active, nonzero write address in the same cycle, rd_data returns that write data. Port 1 has priority if both ports match.
  - rd_busy for that read is 0 unless iss_en targets the same register in the same cycle.
  - This lets writeback and decode meet in the same cycle without a stall.
- **Undefined:** reads return the stored value only, and rd_busy reflects the flop state. The consumer sees the new value one cycle later.

## Structure
- Package regfile_mp_pkg holds:
  - default XLEN and NREGS
  - the reg_addr_t and xlen_t typedefs
  - the ZERO_REG constant
  - the write-port priority constant
- Sub-module regfile_mp_scoreboard holds the busy flops, the set/clear priority logic and the rd_busy lookup.
- Data storage, write arbitration and the read/bypass muxes stay in the top module.

## Test plan
- Reset, then read all registers on both ports → rd_data=0 and busy_vec=0. Assert rst mid-write → the register still reads 0 after release.
- Write 0xDEADBEEF to x5 via port 0 and 0x12345678 to x0 via port 1 → x5 reads 0xDEADBEEF next cycle, x0 reads 0, and busy_vec is unchanged.
- Both ports write x7 in the same cycle (0x1111 on port 0, 0x2222 on port 1) → x7 reads 0x2222.
- Issue x3 → busy_vec[3]=1 next cycle. Write x3 and issue x3 in the same cycle → busy stays 1. Write x3 alone → busy clears the following cycle.
- Same-cycle write of x9=0xCAFE with read of x9:
  - with REGFILE_MP_BYPASS_EN → rd_data=0xCAFE and rd_busy=0 in that cycle
  - without it → old value that cycle, 0xCAFE the next
- NRD=4 and NWR=1 build → all four ports read distinct registers correctly, and a simultaneous read of the same address on all four ports returns the same value.
